// File: rtl/bus_seg_display.sv
// Memory-mapped three-digit seven-segment controller on the MEM-stage data bus.
// Holds DATA/CTRL/RAW registers and time-multiplexes digits onto shared sel/seg pins.
module bus_seg_display #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0010,
  parameter int          CLK_DIV   = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        hit,
  output logic [2:0]  sel,
  output logic [7:0]  seg
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PCNT_LAST = PW'(CLK_DIV - 1);

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_RAW  = 2'd2;

  typedef enum logic {
    ST_OFF  = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  // Bus strobes: a write is accepted on any rising edge where MemWrite and hit
  // are both high; a read is a pure combinational lookup with no wait states.
  logic [1:0]  reg_sel;
  logic        wr_en;
  logic        rd_en;

  logic [11:0] data_q;
  logic [4:0]  ctrl_q;
  logic [23:0] raw_q;

  scan_state_t state_q;
  scan_state_t state_d;
  logic [PW-1:0] pcnt_q;
  logic [PW-1:0] pcnt_d;
  logic [1:0]  idx_q;
  logic [1:0]  idx_d;
  logic [2:0]  sel_d;
  logic [7:0]  seg_d;

  logic [3:0]  cur_nibble;
  logic [7:0]  cur_raw;
  logic        cur_dp;

  logic        unused_bits;
  assign unused_bits = ^{Address[1:0], Write_data[31:24]};

  assign hit     = (Address[31:4] == BASE_ADDR[31:4]);
  assign reg_sel = Address[3:2];
  assign wr_en   = MemWrite && hit;
  assign rd_en   = MemRead && hit;

  // Register file; reserved slot 3 silently drops writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= 12'h000;
      ctrl_q <= 5'h01;
      raw_q  <= 24'hFF_FFFF;
    end else if (wr_en) begin
      case (reg_sel)
        REG_DATA: data_q <= Write_data[11:0];
        REG_CTRL: ctrl_q <= Write_data[4:0];
        REG_RAW:  raw_q  <= Write_data[23:0];
        default:  ;
      endcase
    end
  end

  // Same-cycle read returns the pre-write contents since registers update at the edge.
  always_comb begin
    Read_data = 32'h0;
    if (rd_en) begin
      case (reg_sel)
        REG_DATA: Read_data = {20'h0, data_q};
        REG_CTRL: Read_data = {27'h0, ctrl_q};
        REG_RAW:  Read_data = {8'h0, raw_q};
        default:  Read_data = 32'h0;
      endcase
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h40;
      4'h1: p = 7'h79;
      4'h2: p = 7'h24;
      4'h3: p = 7'h30;
      4'h4: p = 7'h19;
      4'h5: p = 7'h12;
      4'h6: p = 7'h02;
      4'h7: p = 7'h78;
      4'h8: p = 7'h00;
      4'h9: p = 7'h10;
      4'hA: p = 7'h08;
      4'hB: p = 7'h03;
      4'hC: p = 7'h46;
      4'hD: p = 7'h21;
      4'hE: p = 7'h06;
      default: p = 7'h0E;
    endcase
    return p;
  endfunction

  // Per-digit sources for the digit currently being scanned.
  always_comb begin
    cur_nibble = data_q[3:0];
    cur_raw    = raw_q[7:0];
    cur_dp     = ctrl_q[2];
    case (idx_q)
      2'd1: begin
        cur_nibble = data_q[7:4];
        cur_raw    = raw_q[15:8];
        cur_dp     = ctrl_q[3];
      end
      2'd2: begin
        cur_nibble = data_q[11:8];
        cur_raw    = raw_q[23:16];
        cur_dp     = ctrl_q[4];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SCAN;
      pcnt_q  <= '0;
      idx_q   <= 2'd0;
      sel     <= 3'b110;
      seg     <= 8'hC0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      sel     <= sel_d;
      seg     <= seg_d;
    end
  end

  // Counters sit at zero while OFF, so entering SCAN always restarts at digit 0.
  always_comb begin
    state_d = state_q;
    pcnt_d  = '0;
    idx_d   = 2'd0;
    sel_d   = 3'b111;
    seg_d   = 8'hFF;
    case (state_q)
      ST_OFF:  if (ctrl_q[0])  state_d = ST_SCAN;
      ST_SCAN: if (!ctrl_q[0]) state_d = ST_OFF;
      default: state_d = ST_OFF;
    endcase
    if (state_d == ST_SCAN) begin
      if (pcnt_q == PCNT_LAST) begin
        pcnt_d = '0;
        idx_d  = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
        idx_d  = idx_q;
      end
      sel_d = ~(3'b001 << idx_q);
      if (ctrl_q[1]) begin
        seg_d = cur_raw;
      end else begin
        seg_d = {~cur_dp, hex7(cur_nibble)};
      end
    end
  end

endmodule
